wide_adder_seq: RTL

Sequenced multi-word adder. Adds two W-bit operands (W = N*M) in M consecutive cycles by reusing one N-bit `fulladder #(N)` slice, registering the carry between slices. Sits between a requester and a consumer, with valid/ready handshakes on both sides. It provides wide additions without instantiating a W-bit adder.

---
 rtl/wide_adder_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wide_adder_seq.sv
// Sequenced W-bit adder: one N-bit full-adder slice reused over M cycles,
// carry registered between slices, valid/ready handshakes on both sides.

module fulladder #(
   parameter int N = 4
) (
   output logic [N-1:0] sum,
   output logic         cout,
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b
);

   logic [N:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign sum   = total[N-1:0];
   assign cout  = total[N];

endmodule

module wide_adder_seq #(
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*M-1:0] a,
   input  logic [N*M-1:0] b,
   input  logic           cin,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*M-1:0] sum,
   output logic           cout,
   output logic           busy
);

   localparam int W  = N * M;
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   sum_sh;
   logic           carry;
   logic [CW-1:0]  cnt;
   logic           out_valid_q;
   logic           cout_q;
   logic [N-1:0]   slice_sum;
   logic           slice_cout;
   logic [W-1:0]   sum_nxt;

   fulladder #(.N(N)) u_slice (
      .sum  (slice_sum),
      .cout (slice_cout),
      .cin  (carry),
      .a    (a_sh[N-1:0]),
      .b    (b_sh[N-1:0])
   );

   // New slice enters at the MSB; after M slices the LSB slice sits at bit 0.
   assign sum_nxt = W'({slice_sum, sum_sh} >> N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)      state_d = RUN;
         RUN:     if (cnt == LAST)   state_d = DONE;
         DONE:    if (out_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh        <= '0;
         b_sh        <= '0;
         sum_sh      <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         cout_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sum_sh <= sum_nxt;
               a_sh   <= a_sh >> N;
               b_sh   <= b_sh >> N;
               carry  <= slice_cout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_valid_q <= 1'b1;
                  cout_q      <= slice_cout;
               end
            end
            DONE: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_sh;
   assign cout      = cout_q;

endmodule
